// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: N-input, W-bit registered select stage with valid tracking, stall hold and flush.
// Latency: exactly LATENCY (1 or 2) rising edges from input to output when not stalled.
// Backpressure: stall freezes every stage; flush zeroes every stage and overrides stall.
// Optional build macro MUX_SEL_PIPE_RANGE_CHK_EN adds a sticky sel_err output
// that flags an accepted valid input whose sel is outside 0..NUM_IN-1.
module mux_sel_pipe #(
  parameter int WIDTH   = 32,
  parameter int NUM_IN  = 4,   // legal range 2..16
  parameter int LATENCY = 1,   // legal values 1 or 2
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
`ifdef MUX_SEL_PIPE_RANGE_CHK_EN
  output logic                    sel_err,
`endif
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid
);

  logic [WIDTH-1:0] mux;
  logic             advance;
  logic [WIDTH-1:0] stage_data [LATENCY];
  logic             stage_vld  [LATENCY];

  assign advance = !flush && !stall;

  // Select the indexed input; indices past NUM_IN (non power-of-2 counts) give zero, never X.
  always_comb begin
    mux = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        mux = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pipeline stages: reset > flush > stall > advance; bubbles always carry zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        stage_data[s] <= '0;
        stage_vld[s]  <= 1'b0;
      end
    end else if (flush) begin
      for (int s = 0; s < LATENCY; s++) begin
        stage_data[s] <= '0;
        stage_vld[s]  <= 1'b0;
      end
    end else if (!stall) begin
      stage_vld[0]  <= in_valid;
      stage_data[0] <= in_valid ? mux : '0;
      for (int s = 1; s < LATENCY; s++) begin
        stage_data[s] <= stage_data[s-1];
        stage_vld[s]  <= stage_vld[s-1];
      end
    end
  end

  // Output comes straight from the last register, so no input reaches it combinationally.
  assign out_data  = stage_data[LATENCY-1];
  assign out_valid = stage_vld[LATENCY-1];

`ifdef MUX_SEL_PIPE_RANGE_CHK_EN
  logic sel_oor;

  // Range compare done in int so it is exact for every NUM_IN.
  always_comb begin
    sel_oor = (int'(sel) >= NUM_IN);
  end

  // Sticky error: only an accepted (advancing, valid) out-of-range select sets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (advance && in_valid && sel_oor) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: three instances (4 in/lat 1, 4 in/lat 2, 6 in/lat 2) share stimulus.
// Expected outputs come from a queue model: each pipe is a fixed-length queue of tokens.
// Directed scenarios first, then randomized stimulus with stalls, flushes and resets.
module tb_mux_sel_pipe;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } ent_t;
  typedef ent_t eq_t[$];

  logic         clk;
  logic         rst_n;
  logic [31:0]  words [6];
  logic [191:0] in_data6;
  logic [127:0] in_data4;
  logic [2:0]   sel3;
  logic [1:0]   sel2;
  logic         in_valid;
  logic         stall;
  logic         flush;

  logic [31:0]  od_l1, od_l2, od_n6;
  logic         ov_l1, ov_l2, ov_n6;
`ifdef MUX_SEL_PIPE_RANGE_CHK_EN
  logic         err_l1, err_l2, err_n6;
  logic         err_m;
`endif

  eq_t q1, q2, q6;
  int  n_chk;
  int  n_pass;

  always_comb begin
    for (int i = 0; i < 6; i++) in_data6[i*32 +: 32] = words[i];
    in_data4 = in_data6[127:0];
    sel2     = sel3[1:0];
  end

  mux_sel_pipe #(.WIDTH(32), .NUM_IN(4), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .sel(sel2), .in_valid(in_valid),
    .stall(stall), .flush(flush),
`ifdef MUX_SEL_PIPE_RANGE_CHK_EN
    .sel_err(err_l1),
`endif
    .out_data(od_l1), .out_valid(ov_l1));

  mux_sel_pipe #(.WIDTH(32), .NUM_IN(4), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .sel(sel2), .in_valid(in_valid),
    .stall(stall), .flush(flush),
`ifdef MUX_SEL_PIPE_RANGE_CHK_EN
    .sel_err(err_l2),
`endif
    .out_data(od_l2), .out_valid(ov_l2));

  mux_sel_pipe #(.WIDTH(32), .NUM_IN(6), .LATENCY(2)) u_n6 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data6), .sel(sel3), .in_valid(in_valid),
    .stall(stall), .flush(flush),
`ifdef MUX_SEL_PIPE_RANGE_CHK_EN
    .sel_err(err_n6),
`endif
    .out_data(od_n6), .out_valid(ov_n6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // A pipe of depth L holding only bubbles.
  function automatic eq_t empty_q(input int L);
    eq_t q;
    for (int i = 0; i < L; i++) q.push_back('0);
    return q;
  endfunction

  // Token entering a pipe with n inputs this cycle.
  function automatic ent_t token(input int n, input int s);
    ent_t e;
    e.v = in_valid;
    e.d = (in_valid && s < n) ? words[s] : 32'h0;
    return e;
  endfunction

  // One clock of the model: flush empties, stall holds, otherwise shift one token in.
  function automatic eq_t model_step(input eq_t q, input ent_t e);
    eq_t r;
    r = q;
    if (flush) begin
      r = empty_q(q.size());
    end else if (!stall) begin
      r.push_front(e);
      void'(r.pop_back());
    end
    return r;
  endfunction

  task automatic model_reset();
    q1 = empty_q(1);
    q2 = empty_q(2);
    q6 = empty_q(2);
`ifdef MUX_SEL_PIPE_RANGE_CHK_EN
    err_m = 1'b0;
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".l1_data"}, od_l1, q1[$].d);
    chk({tag, ".l1_vld"},  {31'b0, ov_l1}, {31'b0, q1[$].v});
    chk({tag, ".l2_data"}, od_l2, q2[$].d);
    chk({tag, ".l2_vld"},  {31'b0, ov_l2}, {31'b0, q2[$].v});
    chk({tag, ".n6_data"}, od_n6, q6[$].d);
    chk({tag, ".n6_vld"},  {31'b0, ov_n6}, {31'b0, q6[$].v});
`ifdef MUX_SEL_PIPE_RANGE_CHK_EN
    chk({tag, ".l1_err"}, {31'b0, err_l1}, 32'h0);
    chk({tag, ".l2_err"}, {31'b0, err_l2}, 32'h0);
    chk({tag, ".n6_err"}, {31'b0, err_n6}, {31'b0, err_m});
`endif
  endtask

  // Advance one clock: update the model on the rising edge, compare on the falling edge.
  task automatic step(input string tag);
    ent_t e1, e2, e6;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      e1 = token(4, int'(sel2));
      e2 = e1;
      e6 = token(6, int'(sel3));
`ifdef MUX_SEL_PIPE_RANGE_CHK_EN
      if (!flush && !stall && in_valid && sel3 >= 3'd6) err_m = 1'b1;
`endif
      q1 = model_step(q1, e1);
      q2 = model_step(q2, e2);
      q6 = model_step(q6, e6);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic st, input logic fl);
    in_valid = v;
    sel3     = s;
    stall    = st;
    flush    = fl;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    words[3] = 32'hD; words[4] = 32'hE; words[5] = 32'hF;
    drive(1'b1, 3'd2, 1'b0, 1'b0);
    model_reset();

    // Reset values appear with no clock edge at all.
    #2;
    chk("rst_async_data", od_l1, 32'h0);
    chk("rst_async_vld", {31'b0, ov_l1}, 32'h0);
    for (int i = 0; i < 3; i++) step("reset_hold");

    // Release on a falling edge; first rising edge captures input 2.
    rst_n = 1'b1;
    step("basic");
    chk("basic_l1_is_C", od_l1, 32'hC);
    chk("basic_l1_vld", {31'b0, ov_l1}, 32'h1);

    // Back-to-back selects 0..3, then drain.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i), 1'b0, 1'b0);
      step("thru");
      if (i == 1) chk("thru_l2_first_A", od_l2, 32'hA);
    end
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    step("drain");
    step("drain");

    // A then B in flight, 3 stalled cycles, then release.
    drive(1'b1, 3'd0, 1'b0, 1'b0); step("stall_fill");
    drive(1'b1, 3'd1, 1'b0, 1'b0); step("stall_fill");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd3, 1'b1, 1'b0);
      step("stall_hold");
      chk("stall_l2_frozen_A", od_l2, 32'hA);
    end
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    step("stall_rel");
    chk("stall_l2_then_B", od_l2, 32'hB);
    step("stall_rel");

    // Flush with stall and a valid input: everything gone, input dropped.
    drive(1'b1, 3'd2, 1'b0, 1'b0); step("flush_fill");
    drive(1'b1, 3'd3, 1'b0, 1'b0); step("flush_fill");
    drive(1'b1, 3'd1, 1'b1, 1'b1); step("flush");
    chk("flush_l2_vld0", {31'b0, ov_l2}, 32'h0);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    step("post_flush");
    step("post_flush");

    // Out-of-range select on the 6-input pipe, then legal selects.
    drive(1'b1, 3'd7, 1'b0, 1'b0); step("oor");
    drive(1'b1, 3'd5, 1'b0, 1'b0); step("oor");
    chk("oor_n6_zero", od_n6, 32'h0);
    chk("oor_n6_vld", {31'b0, ov_n6}, 32'h1);
    drive(1'b1, 3'd4, 1'b0, 1'b0); step("oor_after");
    step("oor_after");

    // Randomized traffic with occasional stall, flush and mid-stream async reset.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 6; i++) words[i] = $urandom;
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
      if (c % 97 == 50) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_l2_data", od_l2, 32'h0);
        chk("midrst_l2_vld", {31'b0, ov_l2}, 32'h0);
        chk("midrst_n6_vld", {31'b0, ov_n6}, 32'h0);
        model_reset();
        step("midrst");
        rst_n = 1'b1;
      end else begin
        step("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
